olr_ingress_arb: RTL and testbench
==================================

Name: olr_ingress_arb

Overview:
Round-robin, packet-granular arbiter that shares the OLR ingress port (header, payload and completion-status inputs) among NREQ requesters, e.g. buffer and subunit sources. Sits directly upstream of OLR_Ingress. Locks a grant for a whole packet (header plus optional payload burst), enforces a maximum payload length, and drains overlength packets so no stale words leak into later grants.

Parameters:
NREQ, 4, number of requesters (2..8)
HDR_W, 35, header width
PLD_W, 32, payload word width
CS_W, 4, completion-status width
MAX_PLD, 16, maximum payload words per packet (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  NREQ  per-requester header valid
req_hdr  in  NREQ*HDR_W  flattened headers; requester i at bits [i*HDR_W +: HDR_W]
req_cs  in  NREQ*CS_W  flattened completion status
req_has_pld  in  NREQ  header is followed by a payload burst
req_hdr_ready  out  NREQ  header accepted
pld_valid  in  NREQ  payload word valid
pld_data  in  NREQ*PLD_W  flattened payload words
pld_last  in  NREQ  final payload word of the packet
pld_ready  out  NREQ  payload word accepted
header_out  out  HDR_W  to OLR header_in
cs_out  out  CS_W  to OLR completion_status
hdr_out_valid  out  1  header_out/cs_out valid
hdr_out_ready  in  1  downstream accepts header
payload_out  out  PLD_W  to OLR payload_in
pld_out_valid  out  1  payload_out valid
pld_out_ready  in  1  downstream accepts payload word
grant  out  NREQ  one-hot current owner, 0 when idle
busy  out  1  state != IDLE
len_err  out  1  one-cycle pulse on truncation

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high. On reset: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, len_err=0. All valid/ready outputs are 0. Data outputs are don't-care and driven 0.
- States:
  - IDLE: if any req_valid, select the first set bit searching from rr_ptr upward, wrapping modulo NREQ. Register grant and go to HDR. Arbitration costs 1 cycle. No handshake occurs in IDLE.
  - HDR: header_out, cs_out and hdr_out_valid mux combinationally from the granted requester (hdr_out_valid = req_valid[g]); req_hdr_ready[g] = hdr_out_ready. On handshake: if req_has_pld[g], go to PLD with beat_cnt=0; else go to IDLE and set rr_ptr=(g+1)%NREQ.
  - PLD: pld_out_valid = pld_valid[g]; payload_out = pld_data[g]; pld_ready[g] = pld_out_ready. Each handshake increments beat_cnt.
    - Handshake with pld_last: go to IDLE, advance rr_ptr.
    - Handshake with beat_cnt==MAX_PLD-1 and no last: pulse len_err, go to DRAIN.
  - DRAIN: pld_ready[g]=1 and pld_out_valid=0; discard words from g. When a word with pld_last is accepted, go to IDLE and advance rr_ptr.
- Ready outputs of non-granted requesters are always 0. grant holds constant from HDR through PLD/DRAIN.
- A requester is never granted twice in a row while another requester is valid (fairness).
- Only one request valid: it wins regardless of rr_ptr.
- Exactly MAX_PLD words with last on the final word: normal completion, no len_err.
- Dropping req_valid[g] in HDR: hdr_out_valid drops. Grant is held and there is no timeout.
- Downstream stall: outputs stay stable while valid && !ready.
- Reset mid-packet: returns to IDLE next cycle. The partial packet is abandoned; the downstream flush is the system's responsibility.
- beat_cnt width is $clog2(MAX_PLD)+1. rr_ptr width is $clog2(NREQ).

Decomposition:
- olr_pkg: HDR_W/PLD_W/CS_W defaults and the state encoding (IDLE=0, HDR=1, PLD=2, DRAIN=3).
- Sub-module olr_rr_arbiter: combinational rotate-priority picker (inputs req, ptr; output one-hot gnt, any). Reusable for egress buffer selection.

Test Plan:
1. Req1 header-only (hdr=35'h1_2345_6789, cs=4'hA, has_pld=0), hdr_out_ready=1 -> hdr_out_valid at cycle 2, grant=4'b0010, back to IDLE, rr_ptr=2.
2. Req0 and req2 valid together, rr_ptr=0, header-only -> req0 served first, then req2; with req0 re-asserting, the next order is 0,2,0,2.
3. Req3 with 4-word payload (32'hA0..A3), pld_out_ready toggling 1,0,1,0 -> 4 words out in order, no duplicates, stable while stalled, last on A3.
4. Req1 sends 20 words, last on word 20, MAX_PLD=16 -> 16 words forwarded, len_err pulses once on the word-16 handshake, 4 drained with pld_out_valid=0, then IDLE.
5. Reset asserted during PLD beat 2 -> next cycle busy=0, grant=0, all readies 0, rr_ptr=0.
6. Exactly 16 words with last on word 16 -> no len_err, no DRAIN.

Source files
------------

// File: rtl/olr_pkg.sv
// Shared defaults and FSM encoding for the OLR ingress arbiter slice.
package olr_pkg;

    localparam int unsigned HDR_W_DEF = 35;
    localparam int unsigned PLD_W_DEF = 32;
    localparam int unsigned CS_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HDR   = 2'd1,
        PLD   = 2'd2,
        DRAIN = 2'd3
    } arb_state_t;

endpackage

// File: rtl/olr_ingress_arb_if.sv
// Requester-side and OLR-side handshake bundle of the ingress arbiter.
interface olr_ingress_arb_if
    import olr_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned HDR_W = HDR_W_DEF,
    parameter int unsigned PLD_W = PLD_W_DEF,
    parameter int unsigned CS_W  = CS_W_DEF
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ*HDR_W-1:0] req_hdr;
    logic [NREQ*CS_W-1:0]  req_cs;
    logic [NREQ-1:0]       req_has_pld;
    logic [NREQ-1:0]       req_hdr_ready;
    logic [NREQ-1:0]       pld_valid;
    logic [NREQ*PLD_W-1:0] pld_data;
    logic [NREQ-1:0]       pld_last;
    logic [NREQ-1:0]       pld_ready;

    logic [HDR_W-1:0]      header_out;
    logic [CS_W-1:0]       cs_out;
    logic                  hdr_out_valid;
    logic                  hdr_out_ready;
    logic [PLD_W-1:0]      payload_out;
    logic                  pld_out_valid;
    logic                  pld_out_ready;

    logic [NREQ-1:0]       grant;
    logic                  busy;
    logic                  len_err;

    // Requesters plus downstream sink.
    modport master (
        output req_valid, req_hdr, req_cs, req_has_pld,
        output pld_valid, pld_data, pld_last,
        output hdr_out_ready, pld_out_ready,
        input  req_hdr_ready, pld_ready,
        input  header_out, cs_out, hdr_out_valid,
        input  payload_out, pld_out_valid,
        input  grant, busy, len_err
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_hdr, req_cs, req_has_pld,
        input  pld_valid, pld_data, pld_last,
        input  hdr_out_ready, pld_out_ready,
        output req_hdr_ready, pld_ready,
        output header_out, cs_out, hdr_out_valid,
        output payload_out, pld_out_valid,
        output grant, busy, len_err
    );

endinterface

// File: rtl/olr_rr_arbiter.sv
// Combinational rotate-priority picker: first set req bit at or above ptr, wrapping.
module olr_rr_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  gnt,
    output logic             any
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        gnt = '0;
        any = 1'b0;
        idx = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = PTR_W'((32'(ptr) + i) % NREQ);
            if (!any && req[idx]) begin
                gnt[idx] = 1'b1;
                any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/olr_ingress_arb.sv
// Packet-granular round-robin arbiter in front of OLR_Ingress; truncates and
// drains payload bursts longer than MAX_PLD.
module olr_ingress_arb
    import olr_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned HDR_W   = HDR_W_DEF,
    parameter int unsigned PLD_W   = PLD_W_DEF,
    parameter int unsigned CS_W    = CS_W_DEF,
    parameter int unsigned MAX_PLD = 16
) (
    input logic               clk,
    input logic               reset,
    olr_ingress_arb_if.slave  bus
);

    localparam int unsigned PTR_W = $clog2(NREQ);
    localparam int unsigned CNT_W = $clog2(MAX_PLD) + 1;

    arb_state_t       state, state_d;
    logic [PTR_W-1:0] rr_ptr, rr_ptr_d;
    logic [NREQ-1:0]  grant_r, grant_d;
    logic [CNT_W-1:0] beat_cnt, beat_cnt_d;
    logic             len_err_r, len_err_d;

    logic [NREQ-1:0]  arb_gnt;
    logic             arb_any;

    logic [HDR_W-1:0] sel_hdr;
    logic [CS_W-1:0]  sel_cs;
    logic [PLD_W-1:0] sel_data;
    logic [PTR_W-1:0] rr_next;
    logic             sel_valid, sel_has_pld, sel_pld_valid, sel_pld_last;
    logic             hdr_hs, pld_hs, drain_hs, at_max;

    olr_rr_arbiter #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr (
        .req (bus.req_valid),
        .ptr (rr_ptr),
        .gnt (arb_gnt),
        .any (arb_any)
    );

    // Muxing is keyed on the one-hot grant, so no owner index register is kept.
    always_comb begin
        sel_hdr  = '0;
        sel_cs   = '0;
        sel_data = '0;
        rr_next  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_r[i]) begin
                sel_hdr  = bus.req_hdr[i*HDR_W +: HDR_W];
                sel_cs   = bus.req_cs[i*CS_W +: CS_W];
                sel_data = bus.pld_data[i*PLD_W +: PLD_W];
                rr_next  = (i == NREQ - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    assign sel_valid     = |(bus.req_valid   & grant_r);
    assign sel_has_pld   = |(bus.req_has_pld & grant_r);
    assign sel_pld_valid = |(bus.pld_valid   & grant_r);
    assign sel_pld_last  = |(bus.pld_last    & grant_r);

    assign hdr_hs   = (state == HDR)   && sel_valid     && bus.hdr_out_ready;
    assign pld_hs   = (state == PLD)   && sel_pld_valid && bus.pld_out_ready;
    assign drain_hs = (state == DRAIN) && sel_pld_valid;
    assign at_max   = (beat_cnt == CNT_W'(MAX_PLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_r   <= '0;
            beat_cnt  <= '0;
            len_err_r <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            grant_r   <= grant_d;
            beat_cnt  <= beat_cnt_d;
            len_err_r <= len_err_d;
        end
    end

    always_comb begin
        state_d    = state;
        rr_ptr_d   = rr_ptr;
        grant_d    = grant_r;
        beat_cnt_d = beat_cnt;
        len_err_d  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    grant_d = arb_gnt;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (hdr_hs) begin
                    if (sel_has_pld) begin
                        state_d    = PLD;
                        beat_cnt_d = '0;
                    end else begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = rr_next;
                    end
                end
            end
            PLD: begin
                if (pld_hs) begin
                    beat_cnt_d = beat_cnt + CNT_W'(1);
                    // A last word on the final allowed beat is a normal completion.
                    if (sel_pld_last) begin
                        state_d  = IDLE;
                        grant_d  = '0;
                        rr_ptr_d = rr_next;
                    end else if (at_max) begin
                        len_err_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_hs && sel_pld_last) begin
                    state_d  = IDLE;
                    grant_d  = '0;
                    rr_ptr_d = rr_next;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        bus.req_hdr_ready = '0;
        bus.pld_ready     = '0;
        bus.header_out    = '0;
        bus.cs_out        = '0;
        bus.hdr_out_valid = 1'b0;
        bus.payload_out   = '0;
        bus.pld_out_valid = 1'b0;
        case (state)
            HDR: begin
                bus.header_out    = sel_hdr;
                bus.cs_out        = sel_cs;
                bus.hdr_out_valid = sel_valid;
                bus.req_hdr_ready = grant_r & {NREQ{bus.hdr_out_ready}};
            end
            PLD: begin
                bus.payload_out   = sel_data;
                bus.pld_out_valid = sel_pld_valid;
                bus.pld_ready     = grant_r & {NREQ{bus.pld_out_ready}};
            end
            DRAIN: begin
                bus.pld_ready = grant_r;
            end
            default: ;
        endcase
    end

    assign bus.grant   = grant_r;
    assign bus.busy    = (state != IDLE);
    assign bus.len_err = len_err_r;

endmodule

// File: tb/tb_olr_ingress_arb.sv
// Directed bench for olr_ingress_arb: header arbitration table plus payload,
// truncation, stall and reset sequences.
module tb_olr_ingress_arb;

    localparam int NREQ    = 4;
    localparam int HDR_W   = 35;
    localparam int PLD_W   = 32;
    localparam int CS_W    = 4;
    localparam int MAX_PLD = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    olr_ingress_arb_if #(.NREQ(NREQ), .HDR_W(HDR_W), .PLD_W(PLD_W), .CS_W(CS_W)) bus ();

    olr_ingress_arb #(
        .NREQ(NREQ), .HDR_W(HDR_W), .PLD_W(PLD_W), .CS_W(CS_W), .MAX_PLD(MAX_PLD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] valid;
        int         win;
        logic [1:0] rr_after;
    } arb_vec_t;

    arb_vec_t tbl[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [HDR_W-1:0] hdr_of(input int i);
        return 35'h1_2345_6788 + 35'(i);
    endfunction

    function automatic logic [CS_W-1:0] cs_of(input int i);
        return 4'h9 + 4'(i);
    endfunction

    task automatic clear_inputs();
        bus.req_valid     = '0;
        bus.req_has_pld   = '0;
        bus.pld_valid     = '0;
        bus.pld_data      = '0;
        bus.pld_last      = '0;
        bus.hdr_out_ready = 1'b0;
        bus.pld_out_ready = 1'b0;
    endtask

    // Header-only packet from IDLE; leaves the bench at IDLE with mask still driven.
    task automatic hdr_packet(input logic [3:0] mask, input int w, input logic [1:0] rr_after);
        bus.req_valid     = mask;
        bus.req_has_pld   = '0;
        bus.hdr_out_ready = 1'b1;
        #1;
        chk("idle_no_hdr_valid", 64'(bus.hdr_out_valid), 64'd0);
        step();
        chk("arb_grant", 64'(bus.grant), 64'(1) << w);
        chk("hdr_valid", 64'(bus.hdr_out_valid), 64'd1);
        chk("header_out", 64'(bus.header_out), 64'(hdr_of(w)));
        chk("cs_out", 64'(bus.cs_out), 64'(cs_of(w)));
        chk("hdr_ready", 64'(bus.req_hdr_ready), 64'(1) << w);
        step();
        chk("back_idle", 64'(bus.busy), 64'd0);
        chk("grant_cleared", 64'(bus.grant), 64'd0);
        chk("rr_ptr", 64'(dut.rr_ptr), 64'(rr_after));
    endtask

    // Payload packet from requester r: nwords words base+k, last on the final one.
    task automatic run_pkt(input int r, input int nwords, input bit toggle,
                           input logic [31:0] base, input int exp_fwd,
                           input int exp_lenerr, input int exp_drain);
        int sent, fwd, drained, lenerr, cyc;
        logic [3:0] m;
        m = 4'(1 << r);
        sent = 0; fwd = 0; drained = 0; lenerr = 0; cyc = 0;
        bus.req_valid     = m;
        bus.req_has_pld   = m;
        bus.hdr_out_ready = 1'b1;
        bus.pld_out_ready = 1'b1;
        step();
        chk("pkt_grant", 64'(bus.grant), 64'(m));
        chk("pkt_header", 64'(bus.header_out), 64'(hdr_of(r)));
        step();
        bus.req_valid   = '0;
        bus.req_has_pld = '0;
        while (cyc < 300) begin
            if (!bus.busy) break;
            bus.pld_valid = (sent < nwords) ? m : 4'b0;
            bus.pld_last  = (sent == nwords - 1) ? m : 4'b0;
            bus.pld_data  = '0;
            bus.pld_data[r*PLD_W +: PLD_W] = base + 32'(sent);
            bus.pld_out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (bus.len_err) lenerr++;
            if (bus.pld_out_valid) begin
                chk("payload_word", 64'(bus.payload_out), 64'(base + 32'(fwd)));
                if (bus.pld_out_ready) fwd++;
            end
            chk("pld_ready_others", 64'(bus.pld_ready & ~m), 64'd0);
            chk("grant_held", 64'(bus.grant), 64'(m));
            if (bus.pld_ready[r] && bus.pld_valid[r]) begin
                sent++;
                if (!bus.pld_out_valid) drained++;
            end
            step();
            cyc++;
        end
        chk("pkt_timeout", 64'(cyc < 300), 64'd1);
        bus.pld_valid = '0;
        bus.pld_last  = '0;
        chk("pkt_forwarded", 64'(fwd), 64'(exp_fwd));
        chk("pkt_len_err", 64'(lenerr), 64'(exp_lenerr));
        chk("pkt_drained", 64'(drained), 64'(exp_drain));
        chk("pkt_consumed", 64'(sent), 64'(nwords));
        chk("pkt_grant_cleared", 64'(bus.grant), 64'd0);
    endtask

    initial begin
        tbl[0]  = '{4'b0010, 1, 2'd2};
        tbl[1]  = '{4'b1000, 3, 2'd0};
        tbl[2]  = '{4'b0101, 0, 2'd1};
        tbl[3]  = '{4'b0101, 2, 2'd3};
        tbl[4]  = '{4'b0101, 0, 2'd1};
        tbl[5]  = '{4'b0101, 2, 2'd3};
        tbl[6]  = '{4'b1111, 3, 2'd0};
        tbl[7]  = '{4'b1111, 0, 2'd1};
        tbl[8]  = '{4'b0110, 1, 2'd2};
        tbl[9]  = '{4'b0110, 2, 2'd3};
        tbl[10] = '{4'b0011, 0, 2'd1};

        clear_inputs();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_hdr[i*HDR_W +: HDR_W] = hdr_of(i);
            bus.req_cs[i*CS_W +: CS_W]    = cs_of(i);
        end
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_grant", 64'(bus.grant), 64'd0);
        chk("rst_len_err", 64'(bus.len_err), 64'd0);
        chk("rst_valids", 64'({bus.hdr_out_valid, bus.pld_out_valid}), 64'd0);
        chk("rst_readies", 64'({bus.req_hdr_ready, bus.pld_ready}), 64'd0);
        reset = 1'b0;

        for (int k = 0; k < 11; k++)
            hdr_packet(tbl[k].valid, tbl[k].win, tbl[k].rr_after);
        bus.req_valid = '0;

        // Header stall, then requester drops valid while the grant is held.
        bus.req_valid     = 4'b0001;
        bus.hdr_out_ready = 1'b0;
        step();
        chk("hold_grant", 64'(bus.grant), 64'h1);
        chk("hold_hdr_ready", 64'(bus.req_hdr_ready), 64'd0);
        step();
        chk("stall_header_stable", 64'(bus.header_out), 64'(hdr_of(0)));
        chk("stall_hdr_valid", 64'(bus.hdr_out_valid), 64'd1);
        bus.req_valid     = 4'b0100;
        bus.hdr_out_ready = 1'b1;
        #1;
        chk("drop_hdr_valid", 64'(bus.hdr_out_valid), 64'd0);
        repeat (3) step();
        chk("drop_grant_held", 64'(bus.grant), 64'h1);
        chk("drop_busy", 64'(bus.busy), 64'd1);
        bus.req_valid = 4'b0101;
        step();
        chk("drop_done", 64'(bus.busy), 64'd0);
        chk("drop_rr", 64'(dut.rr_ptr), 64'd1);
        step();
        chk("fair_next", 64'(bus.grant), 64'b0100);
        step();
        bus.req_valid = '0;
        chk("fair_rr", 64'(dut.rr_ptr), 64'd3);

        run_pkt(3, 4, 1'b1, 32'hA0, 4, 0, 0);
        chk("rr_after_req3", 64'(dut.rr_ptr), 64'd0);
        run_pkt(1, 20, 1'b0, 32'h1000, 16, 1, 4);
        chk("rr_after_req1", 64'(dut.rr_ptr), 64'd2);
        run_pkt(2, 16, 1'b0, 32'h2000, 16, 0, 0);
        chk("rr_after_req2", 64'(dut.rr_ptr), 64'd3);

        // Reset while the payload burst of req2 is on beat 2.
        bus.req_valid     = 4'b0100;
        bus.req_has_pld   = 4'b0100;
        bus.hdr_out_ready = 1'b1;
        step();
        step();
        bus.req_valid     = '0;
        bus.req_has_pld   = '0;
        bus.pld_valid     = 4'b0100;
        bus.pld_data      = '0;
        bus.pld_data[2*PLD_W +: PLD_W] = 32'h3000;
        bus.pld_out_ready = 1'b1;
        step();
        step();
        chk("mid_pld_valid", 64'(bus.pld_out_valid), 64'd1);
        chk("mid_beat_cnt", 64'(dut.beat_cnt), 64'd2);
        reset = 1'b1;
        step();
        chk("mrst_busy", 64'(bus.busy), 64'd0);
        chk("mrst_grant", 64'(bus.grant), 64'd0);
        chk("mrst_readies", 64'({bus.req_hdr_ready, bus.pld_ready}), 64'd0);
        chk("mrst_pld_valid", 64'(bus.pld_out_valid), 64'd0);
        chk("mrst_rr", 64'(dut.rr_ptr), 64'd0);
        reset = 1'b0;
        clear_inputs();

        hdr_packet(4'b1010, 1, 2'd2);
        bus.req_valid = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
